// File: rtl/mon2_pkg.sv
// mon2_pkg: shared types for the monitor-2 trace buffer.
//   - RISC-V major opcodes used for classification
//   - mon2_kind_e : record kind (other / load / store)
//   - mon2_rec_t  : 71-bit packed trace record {kind, dptr, addr, data}
//   - mon2_classify() : opcode -> record kind
package mon2_pkg;

  localparam logic [6:0] I_L_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE   = 7'b0100011;

  typedef enum logic [1:0] {
    OTHER = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mon2_kind_e;

  typedef struct packed {
    mon2_kind_e  kind;
    logic [4:0]  dptr;
    logic [31:0] addr;
    logic [31:0] data;
  } mon2_rec_t;

  function automatic mon2_kind_e mon2_classify(input logic [6:0] opcode);
    case (opcode)
      I_L_TYPE: return LOAD;
      S_TYPE:   return STORE;
      default:  return OTHER;
    endcase
  endfunction

endpackage

// File: rtl/mon2_trace_buffer_if.sv
// mon2_trace_buffer_if: record stream from the trace buffer to its consumer.
//   OUT_VALID  head record available (source -> sink)
//   OUT_READY  sink accepts head record (sink -> source)
//   OUT_KIND   0 other, 1 load, 2 store
//   OUT_DPTR   recorded destination register
//   OUT_ADDR   recorded data address (0 for other)
//   OUT_DATA   load data / store data / writeback result
// master = record source (the trace buffer), slave = consumer.
interface mon2_trace_buffer_if;

  logic        OUT_VALID;
  logic        OUT_READY;
  logic [1:0]  OUT_KIND;
  logic [4:0]  OUT_DPTR;
  logic [31:0] OUT_ADDR;
  logic [31:0] OUT_DATA;

  modport master (
    output OUT_VALID, OUT_KIND, OUT_DPTR, OUT_ADDR, OUT_DATA,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID, OUT_KIND, OUT_DPTR, OUT_ADDR, OUT_DATA,
    output OUT_READY
  );

endinterface

// File: rtl/mon2_fifo.sv
// mon2_fifo: synchronous FIFO of mon2_rec_t records.
//   clk      clock, all updates on posedge
//   rst      synchronous active-high reset (pointers and count only)
//   i_push   write i_wdata at the tail (accepted if not full, or popping)
//   i_wdata  record to write
//   i_pop    consume the head (ignored while empty)
//   o_rdata  head record, read combinationally from storage
//   o_count  occupancy, 0..DEPTH
//   o_full   occupancy == DEPTH
//   o_empty  occupancy == 0
module mon2_fifo
  import mon2_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  mon2_rec_t                i_wdata,
  input  logic                     i_pop,
  output mon2_rec_t                o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  mon2_rec_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: storage has no reset; only pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap modulo DEPTH because DEPTH is a power of two.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mon2_trace_buffer.sv
// mon2_trace_buffer: captures one trace record per non-halted cycle from the
// darksocv monitor-2 bundle, buffers it, and streams it to a consumer.
//   CLK, RES          clock / synchronous active-high reset
//   EN, HLT           capture enable / core halt (no capture while halted)
//   XIDATA            instruction word; [6:0] selects load / store / other
//   DPTR              destination register index
//   DADDR             data byte address (window-checked for loads/stores)
//   LDATA/DATAO/RMDATA load result / store data / writeback result
//   out_if            record stream (master side)
//   COUNT             buffer occupancy
//   DROP_CNT          saturating count of records lost to a full buffer
//   WIN_ERR_CNT       saturating count of loads/stores outside [WIN_LO, WIN_HI]
//   WIN_ERR           sticky flag, set on the first window violation
module mon2_trace_buffer
  import mon2_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIN_LO = 512,
  parameter int unsigned WIN_HI = 1023
) (
  input  logic                   CLK,
  input  logic                   RES,
  input  logic                   EN,
  input  logic                   HLT,
  input  logic [31:0]            XIDATA,
  input  logic [4:0]             DPTR,
  input  logic [31:0]            DADDR,
  input  logic [31:0]            LDATA,
  input  logic [31:0]            DATAO,
  input  logic [31:0]            RMDATA,
  mon2_trace_buffer_if.master    out_if,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic [15:0]            DROP_CNT,
  output logic [15:0]            WIN_ERR_CNT,
  output logic                   WIN_ERR
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic        w_capture;
  mon2_kind_e  w_kind;
  logic        w_is_mem;
  logic [29:0] w_word;
  logic        w_win_viol;
  mon2_rec_t   w_rec;
  mon2_rec_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_unused_bits;

  logic [15:0] r_drop_cnt;
  logic [15:0] r_win_err_cnt;
  logic        r_win_err;

  assign w_capture  = EN && !HLT && !RES;
  assign w_kind     = mon2_classify(XIDATA[6:0]);
  assign w_is_mem   = (w_kind != OTHER);
  assign w_word     = DADDR[31:2];
  assign w_win_viol = w_is_mem && ((w_word < 30'(WIN_LO)) || (w_word > 30'(WIN_HI)));

  // Only the opcode field and the word index matter here.
  assign w_unused_bits = ^{XIDATA[31:7], DADDR[1:0]};

  // NOTE: every field gets a default first so this block can never infer a latch.
  always_comb begin
    w_rec      = '0;
    w_rec.kind = w_kind;
    w_rec.dptr = DPTR;
    w_rec.addr = w_is_mem ? DADDR : 32'd0;
    case (w_kind)
      LOAD:    w_rec.data = LDATA;
      STORE:   w_rec.data = DATAO;
      default: w_rec.data = RMDATA;
    endcase
  end

  // Valid comes only from occupancy, so ready never feeds back into valid.
  assign w_pop  = !w_empty && out_if.OUT_READY;
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && w_full && !w_pop;

  mon2_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RES),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (COUNT),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Violations are counted on capture, independent of whether the record fits.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_drop_cnt    <= '0;
      r_win_err_cnt <= '0;
      r_win_err     <= 1'b0;
    end else begin
      if (w_drop && (r_drop_cnt != CNT_MAX)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_capture && w_win_viol) begin
        if (r_win_err_cnt != CNT_MAX) r_win_err_cnt <= r_win_err_cnt + 16'd1;
        r_win_err <= 1'b1;
      end
    end
  end

  assign DROP_CNT    = r_drop_cnt;
  assign WIN_ERR_CNT = r_win_err_cnt;
  assign WIN_ERR     = r_win_err;

  assign out_if.OUT_VALID = !w_empty;
  assign out_if.OUT_KIND  = w_head.kind;
  assign out_if.OUT_DPTR  = w_head.dptr;
  assign out_if.OUT_ADDR  = w_head.addr;
  assign out_if.OUT_DATA  = w_head.data;

endmodule

// File: tb/tb_mon2_trace_buffer.sv
// tb_mon2_trace_buffer: randomized + directed stimulus against a queue-based
// reference model; a separate monitor compares every record the DUT hands over.
module tb_mon2_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  dptr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        res;
  logic        en;
  logic        hlt;
  logic [31:0] xidata;
  logic [4:0]  dptr;
  logic [31:0] daddr;
  logic [31:0] ldata;
  logic [31:0] datao;
  logic [31:0] rmdata;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  logic [15:0] win_err_cnt;
  logic        win_err;

  mon2_trace_buffer_if out_if ();

  mon2_trace_buffer #(
    .DEPTH  (DEPTH),
    .WIN_LO (512),
    .WIN_HI (1023)
  ) dut (
    .CLK         (clk),
    .RES         (res),
    .EN          (en),
    .HLT         (hlt),
    .XIDATA      (xidata),
    .DPTR        (dptr),
    .DADDR       (daddr),
    .LDATA       (ldata),
    .DATAO       (datao),
    .RMDATA      (rmdata),
    .out_if      (out_if),
    .COUNT       (count),
    .DROP_CNT    (drop_cnt),
    .WIN_ERR_CNT (win_err_cnt),
    .WIN_ERR     (win_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests  = 0;
  int failed = 0;

  // Reference model: sb_q is the ordered set of records the DUT must emit.
  exp_t sb_q[$];
  int   m_count = 0, m_drop = 0, m_werr_cnt = 0;
  bit   m_werr = 1'b0;
  // State the DUT should be showing during the current cycle.
  int   v_count = 0, v_drop = 0, v_werr_cnt = 0;
  bit   v_werr = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Applies the current inputs to the model for the coming edge, then steps
  // to just after that edge.
  task automatic cycle();
    bit   cap, pop, push, viol;
    int   word;
    exp_t r;
    if (res) out_if.OUT_READY = 1'b0;
    v_count = m_count; v_drop = m_drop; v_werr_cnt = m_werr_cnt; v_werr = m_werr;
    if (res) begin
      m_count = 0; m_drop = 0; m_werr_cnt = 0; m_werr = 1'b0;
      sb_q.delete();
    end else begin
      cap  = en && !hlt;
      pop  = (m_count > 0) && out_if.OUT_READY;
      push = cap && ((m_count < DEPTH) || pop);
      r.dptr = dptr;
      if (xidata[6:0] == 7'h03)      begin r.kind = 2'd1; r.data = ldata; end
      else if (xidata[6:0] == 7'h23) begin r.kind = 2'd2; r.data = datao; end
      else                           begin r.kind = 2'd0; r.data = rmdata; end
      r.addr = (r.kind != 2'd0) ? daddr : 32'd0;
      word   = int'(daddr >> 2);
      viol   = (r.kind != 2'd0) && ((word < 512) || (word > 1023));
      if (cap && viol) begin
        if (m_werr_cnt < 16'hFFFF) m_werr_cnt++;
        m_werr = 1'b1;
      end
      if (cap && !push && (m_drop < 16'hFFFF)) m_drop++;
      if (push) sb_q.push_back(r);
      m_count += int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  // kind_sel: 0 other, 1 load, 2 store, 3 random pick.
  task automatic rand_inputs(input int kind_sel);
    int k;
    k = (kind_sel == 3) ? int'($urandom_range(0, 2)) : kind_sel;
    xidata = $urandom();
    case (k)
      1:       xidata[6:0] = 7'b0000011;
      2:       xidata[6:0] = 7'b0100011;
      default: xidata[6:0] = 7'b0110011;
    endcase
    dptr   = 5'($urandom());
    daddr  = {30'($urandom_range(480, 1060)), 2'($urandom())};
    ldata  = $urandom();
    datao  = $urandom();
    rmdata = $urandom();
  endtask

  // Monitor: on each falling edge compare status and any record handed over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count",       64'(count),       64'(v_count));
        check("out_valid",   64'(out_if.OUT_VALID), 64'(v_count != 0));
        check("drop_cnt",    64'(drop_cnt),    64'(v_drop));
        check("win_err_cnt", 64'(win_err_cnt), 64'(v_werr_cnt));
        check("win_err",     64'(win_err),     64'(v_werr));
        if (out_if.OUT_VALID === 1'b1 && out_if.OUT_READY === 1'b1) begin
          if (sb_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_record: got kind %0d data 0x%0h, expected no record",
                     out_if.OUT_KIND, out_if.OUT_DATA);
          end else begin
            e = sb_q.pop_front();
            check("rec_kind", 64'(out_if.OUT_KIND), 64'(e.kind));
            check("rec_dptr", 64'(out_if.OUT_DPTR), 64'(e.dptr));
            check("rec_addr", 64'(out_if.OUT_ADDR), 64'(e.addr));
            check("rec_data", 64'(out_if.OUT_DATA), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1; en = 1'b0; hlt = 1'b0;
    xidata = '0; dptr = '0; daddr = '0; ldata = '0; datao = '0; rmdata = '0;
    out_if.OUT_READY = 1'b0;
    @(posedge clk); #1;
    cycle();
    check("reset_count", 64'(count), 64'd0);
    check("reset_valid", 64'(out_if.OUT_VALID), 64'd0);
    res = 1'b0;
    mon_en = 1'b1;

    // Load at word 512 (inside the window).
    en = 1'b1; xidata = 32'h00002083; dptr = 5'd1; daddr = 32'h0000_0800; ldata = 32'hDEADBEEF;
    cycle();
    en = 1'b0;
    check("load_valid", 64'(out_if.OUT_VALID), 64'd1);
    check("load_kind",  64'(out_if.OUT_KIND),  64'd1);
    check("load_addr",  64'(out_if.OUT_ADDR),  64'h800);
    check("load_data",  64'(out_if.OUT_DATA),  64'hDEADBEEF);
    check("load_werr",  64'(win_err),          64'd0);

    // Stores at words 1024 and 511: both violate, both are buffered.
    en = 1'b1; xidata = 32'h0020A023; datao = 32'h1111_2222; daddr = 32'h0000_1000;
    cycle();
    datao = 32'h3333_4444; daddr = 32'h0000_07FC;
    cycle();
    en = 1'b0;
    check("st_werr_cnt", 64'(win_err_cnt), 64'd2);
    check("st_werr",     64'(win_err),     64'd1);
    check("st_count",    64'(count),       64'd3);
    out_if.OUT_READY = 1'b1;
    repeat (4) cycle();
    check("drain1_count", 64'(count), 64'd0);

    // 20 captures into a stalled consumer: 16 kept, 4 dropped.
    out_if.OUT_READY = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_inputs(0);
      cycle();
    end
    check("full_count", 64'(count),    64'd16);
    check("full_drop",  64'(drop_cnt), 64'd4);

    // Full with capture and pop together: accepted, no drop.
    rand_inputs(1);
    daddr = 32'h0000_0A00;
    out_if.OUT_READY = 1'b1;
    cycle();
    en = 1'b0;
    check("fullpp_count", 64'(count),    64'd16);
    check("fullpp_drop",  64'(drop_cnt), 64'd4);
    repeat (17) cycle();
    check("drain2_count", 64'(count), 64'd0);

    // Halted core or disabled capture: nothing enters.
    out_if.OUT_READY = 1'b0;
    en = 1'b1; hlt = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_inputs(3); cycle(); end
    check("hlt_count", 64'(count), 64'd0);
    en = 1'b0; hlt = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_inputs(3); cycle(); end
    check("en0_count", 64'(count), 64'd0);

    // Reach COUNT=7, DROP_CNT=3 with a window error, then reset mid-operation.
    res = 1'b1; cycle(); res = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      rand_inputs(1);
      if (i == 0) daddr = 32'h0000_0100;
      cycle();
    end
    en = 1'b0;
    out_if.OUT_READY = 1'b1;
    repeat (9) cycle();
    check("pre_rst_count", 64'(count),    64'd7);
    check("pre_rst_drop",  64'(drop_cnt), 64'd3);
    check("pre_rst_werr",  64'(win_err),  64'd1);
    res = 1'b1;
    cycle();
    res = 1'b0;
    check("rst_count", 64'(count),            64'd0);
    check("rst_valid", 64'(out_if.OUT_VALID), 64'd0);
    check("rst_drop",  64'(drop_cnt),         64'd0);
    check("rst_werr",  64'(win_err),          64'd0);
    en = 1'b1; out_if.OUT_READY = 1'b0;
    rand_inputs(2);
    daddr = 32'h0000_0900;
    cycle();
    en = 1'b0;
    check("post_rst_valid", 64'(out_if.OUT_VALID), 64'd1);
    check("post_rst_kind",  64'(out_if.OUT_KIND),  64'd2);
    check("post_rst_addr",  64'(out_if.OUT_ADDR),  64'h900);

    // Randomized traffic with stalls, halts and rare resets.
    for (int i = 0; i < 400; i++) begin
      res = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      hlt = ($urandom_range(0, 7) == 0);
      out_if.OUT_READY = ($urandom_range(0, 2) != 0);
      rand_inputs(3);
      cycle();
    end
    res = 1'b0; en = 1'b0; hlt = 1'b0;
    out_if.OUT_READY = 1'b1;
    repeat (DEPTH + 2) cycle();
    check("final_count", 64'(count), 64'd0);
    check("sb_drained",  64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mon2_trace_buffer.md
# mon2_trace_buffer

Testbench-side trace collector that sits directly downstream of the monitor-2 signal bundle of the darksocv core. Every cycle the core is not halted, it classifies the executing instruction (load / store / other), packs the relevant operands into a fixed-width record and buffers it in a FIFO. The scoreboard drains records through a valid/ready handshake. The block also counts data-window violations and dropped records.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `WIN_LO`, 512: lowest legal data word index (DADDR/4), inclusive.
- `WIN_HI`, 1023: highest legal data word index, inclusive.
- `CLK` in 1: single clock; all state updates on posedge.
- `RES` in 1: synchronous, active-high reset.
- `EN` in 1: capture enable.
- `HLT` in 1: core halt; no capture while high.
- `XIDATA` in 32: current instruction word.
- `DPTR` in 5: destination register index.
- `DADDR` in 32: data memory byte address.
- `LDATA` in 32: load result.
- `DATAO` in 32: store data.
- `RMDATA` in 32: ALU/writeback result.
- `OUT_VALID` out 1: head record available.
- `OUT_READY` in 1: consumer accepts head record.
- `OUT_KIND` out 2: 0 = other, 1 = load, 2 = store; 3 is unused.
- `OUT_DPTR` out 5: recorded DPTR.
- `OUT_ADDR` out 32: recorded DADDR; 0 for kind other.
- `OUT_DATA` out 32: LDATA for load, DATAO for store, RMDATA for other.
- `COUNT` out $clog2(DEPTH)+1: current occupancy.
- `DROP_CNT` out 16: records lost to full FIFO; saturating.
- `WIN_ERR_CNT` out 16: loads/stores outside the data window; saturating.
- `WIN_ERR` out 1: sticky; set on the first window violation.

## Operation
- Capture condition: `EN && !HLT && !RES`, sampled at posedge.
- Classification uses `XIDATA[6:0]`:
  - 7'b0000011 gives load.
  - 7'b0100011 gives store.
  - Any other value gives other.
- Window check applies to load and store only. Violation when `DADDR[31:2] < WIN_LO` or `DADDR[31:2] > WIN_HI`.
  - A violation is counted whether or not the record is dropped.
  - A violating record is still buffered normally.
- Push happens when the capture condition holds and (COUNT < DEPTH, or a pop occurs in the same cycle).
- Pop happens when `OUT_VALID && OUT_READY`.
- Full FIFO with capture and no pop: record discarded, DROP_CNT += 1 (saturates at 16'hFFFF).
- Simultaneous push and pop: COUNT unchanged; both pointers advance.
- Simultaneous push and pop when full: push accepted, no drop.
- Empty FIFO: no pop; there is no bypass from input to output.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `OUT_*` fields are the head entry, read combinationally from storage. They are undefined-but-stable while OUT_VALID = 0.
- Reset values:
  - COUNT = 0, OUT_VALID = 0.
  - Pointers = 0.
  - DROP_CNT = 0, WIN_ERR_CNT = 0, WIN_ERR = 0.
  - Storage contents are not reset.
- Reset mid-operation discards all buffered records and clears all counters in the same edge.

## Timing
- Latency is 1 cycle: a capture at edge N makes the record visible on OUT_* with OUT_VALID = 1 after edge N.
- OUT_VALID = (COUNT != 0), registered-derived; it never depends combinationally on OUT_READY.
- OUT_READY may be high while OUT_VALID = 0; this has no effect.
- Consumer holding OUT_READY = 1 drains one record per cycle.
- Throughput: one capture per cycle sustained, provided OUT_READY stays high.
- Counters and WIN_ERR update at the same edge as the capture that caused them.

## Structure
- Shared package `mon2_pkg` holds:
  - opcode constants `I_L_TYPE` = 7'b0000011 and `S_TYPE` = 7'b0100011;
  - enum `mon2_kind_e` (OTHER, LOAD, STORE);
  - packed struct `mon2_rec_t` {kind, dptr, addr, data} = 71 bits.
- Sub-module `mon2_fifo`: parameterised synchronous FIFO of `mon2_rec_t` with push/pop/count/full/empty.
- The top level contains classification, window check, drop logic and the counters.

## Test plan
- Reset, then capture load `XIDATA=32'h00002083`, `DADDR=32'h0000_0800` (word 512), `LDATA=32'hDEADBEEF` → next cycle OUT_VALID=1, KIND=1, ADDR=32'h800, DATA=32'hDEADBEEF, WIN_ERR=0.
- Store with `DADDR=32'h0000_1000` (word 1024), then store with `DADDR=32'h0000_07FC` (word 511) → WIN_ERR_CNT=2, WIN_ERR=1; both records still buffered.
- OUT_READY=0, 20 back-to-back captures with DEPTH=16 → COUNT=16, DROP_CNT=4; draining yields the first 16 records in order.
- Full FIFO, capture and OUT_READY=1 in the same cycle → COUNT stays 16, DROP_CNT unchanged, new record lands at the tail.
- HLT=1 for 5 cycles during active instructions → no COUNT change; EN=0 behaves the same.
- Assert RES with COUNT=7, DROP_CNT=3 → after the edge COUNT=0, OUT_VALID=0, DROP_CNT=0, WIN_ERR=0; a capture in the following cycle works normally.
